// File: rtl/jtdd_romrq_pkg.sv
// Shared definitions for the jtdd_romrq ROM slot responder:
// FSM state encoding and the SDRAM-side bus geometry.
package jtdd_romrq_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SDRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/jtdd_romrq_if.sv
// Bus bundle for one ROM slot: consumer side (cs/addr/dout/ok), the
// download flag and the SDRAM controller side (req/addr/ack/rdy/data).
// The responder uses the slave modport; whoever drives requests and
// plays the SDRAM controller uses the master modport.
interface jtdd_romrq_if
    import jtdd_romrq_pkg::*;
#(
    parameter int AW = 18,
    parameter int DW = 8
);
    logic                cs;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       dout;
    logic                ok;
    logic                downloading;
    logic                sdram_req;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [SDRAM_DW-1:0] data_read;

    modport slave (
        input  cs, addr, downloading, sdram_ack, data_rdy, data_read,
        output dout, ok, sdram_req, sdram_addr
    );

    modport master (
        output cs, addr, downloading, sdram_ack, data_rdy, data_read,
        input  dout, ok, sdram_req, sdram_addr
    );

endinterface

// File: rtl/jtdd_romrq_entry.sv
// One cache line of the ROM slot responder: valid bit, word-address tag
// and the 16-bit SDRAM word. Reports a combinational tag match and
// accepts a fill through a single write port. clr drops the valid bit
// (used while a ROM download is rewriting SDRAM).
module jtdd_romrq_entry
    import jtdd_romrq_pkg::*;
#(
    parameter int TW = 18
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [TW-1:0]       wtag,
    input  logic [SDRAM_DW-1:0] wdata,
    input  logic [TW-1:0]       tag,
    output logic                match,
    output logic [SDRAM_DW-1:0] data
);

    logic                valid;
    logic [TW-1:0]       tag_q;
    logic [SDRAM_DW-1:0] data_q;

    // Line storage: invalidate on reset or download, otherwise take fills
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else if (clr) begin
            valid  <= 1'b0;
        end else if (we) begin
            valid  <= 1'b1;
            tag_q  <= wtag;
            data_q <= wdata;
        end
    end

    assign match = valid && (tag_q == tag);
    assign data  = data_q;

endmodule

// File: rtl/jtdd_romrq.sv
// jtdd_romrq: SDRAM-side responder for one game ROM slot.
// Converts consumer reads (cs/addr) into 16-bit SDRAM word reads, keeps
// the last fetched word(s) and flags dout as valid through ok.
// Build option: define JTDD_ROMRQ_DUAL_EN for a two-line cache with LRU
// replacement; without it a single cache line is used.
module jtdd_romrq
    import jtdd_romrq_pkg::*;
#(
    parameter int                  AW     = 18,
    parameter int                  DW     = 8,
    parameter logic [SDRAM_AW-1:0] OFFSET = '0
)(
    input  logic        clk,
    input  logic        rst,
    jtdd_romrq_if.slave bus
);

`ifdef JTDD_ROMRQ_DUAL_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    state_t              state;
    state_t              next_state;
    logic [AW-1:0]       wa;
    logic [SDRAM_AW-1:0] req_addr;
    logic [SDRAM_AW-1:0] sdram_addr_q;
    logic [AW-1:0]       req_tag;
    logic [NE-1:0]       ent_match;
    logic [NE-1:0]       ent_we;
    logic [SDRAM_DW-1:0] ent_data [NE];
    logic [SDRAM_DW-1:0] hit_data;
    logic                hit;
    logic                rd_ok;
    logic                fill;

    // Word address: byte consumers drop the byte-select bit
    always_comb begin
        wa = bus.addr;
        if (DW == 8) begin
            wa = {1'b0, bus.addr[AW-1:1]};
        end
    end

    assign req_addr = OFFSET + SDRAM_AW'(wa);

    for (genvar i = 0; i < NE; i++) begin : g_entry
        jtdd_romrq_entry #(.TW(AW)) u_entry (
            .clk   (clk),
            .rst   (rst),
            .clr   (bus.downloading),
            .we    (ent_we[i]),
            .wtag  (req_tag),
            .wdata (bus.data_read),
            .tag   (wa),
            .match (ent_match[i]),
            .data  (ent_data[i])
        );
    end

    assign hit   = |ent_match;
    assign rd_ok = bus.cs && hit && !bus.downloading;

    // Pick the word of whichever line matches the current address
    always_comb begin
        hit_data = ent_data[0];
        for (int i = 1; i < NE; i++) begin
            if (ent_match[i]) begin
                hit_data = ent_data[i];
            end
        end
    end

    // Present the addressed byte (DW=8) or the whole word (DW=16)
    always_comb begin
        if (DW == 8) begin
            bus.dout = DW'(bus.addr[0] ? hit_data[15:8] : hit_data[7:0]);
        end else begin
            bus.dout = DW'(hit_data);
        end
    end

    // Request sequencing: miss -> REQ until ack -> WAIT until data -> fill
    always_comb begin
        next_state = state;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cs && !hit) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_rdy) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (bus.downloading) begin
            next_state = IDLE;
            fill       = 1'b0;
        end
    end

    // State register; the request address and tag are frozen on entry to REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sdram_addr_q <= '0;
            req_tag      <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == REQ) begin
                sdram_addr_q <= req_addr;
                req_tag      <= wa;
            end
        end
    end

`ifdef JTDD_ROMRQ_DUAL_EN
    logic lru;

    // Track the line to evict next: a filled or hit line becomes MRU
    always_ff @(posedge clk) begin
        if (rst || bus.downloading) begin
            lru <= 1'b0;
        end else if (fill) begin
            lru <= ~lru;
        end else if (rd_ok) begin
            lru <= ent_match[0];
        end
    end

    // Route a fill to the least recently used line
    always_comb begin
        ent_we      = '0;
        ent_we[lru] = fill;
    end
`else
    // Single line: every fill overwrites it
    always_comb begin
        ent_we    = '0;
        ent_we[0] = fill;
    end
`endif

    assign bus.ok         = rd_ok;
    assign bus.sdram_req  = (state == REQ) && !bus.downloading;
    assign bus.sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtdd_romrq.sv
// Testbench for jtdd_romrq (AW=18, DW=8, OFFSET=22'h1000).
// Expected SDRAM addresses and read bytes are queued as stimulus is
// issued; a negedge monitor pops them when the DUT raises sdram_req or
// presents valid data. Build with JTDD_ROMRQ_DUAL_EN for the two-line cache.
module tb_jtdd_romrq;
    import jtdd_romrq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks    = 0;
    int failures  = 0;
    int req_count = 0;

    logic [21:0] exp_req_q  [$];
    logic [7:0]  exp_data_q [$];

    logic        prev_req  = 1'b0;
    logic        prev_ok   = 1'b0;
    logic [17:0] prev_addr = '0;
    logic [21:0] mon_req;
    logic [7:0]  mon_data;

`ifdef JTDD_ROMRQ_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    jtdd_romrq_if #(.AW(18), .DW(8)) bus ();

    jtdd_romrq #(.AW(18), .DW(8), .OFFSET(22'h1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cs, input logic [17:0] addr);
        bus.cs   = cs;
        bus.addr = addr;
    endtask

    task automatic waitReq();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.sdram_req) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("req_seen", 32'(seen), 32'd1);
    endtask

    task automatic ackReq();
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
    endtask

    task automatic dataRdy(input logic [15:0] word);
        bus.data_rdy  = 1'b1;
        bus.data_read = word;
        tick();
        bus.data_rdy  = 1'b0;
    endtask

    // One consumer read: miss is served by the bench acting as SDRAM
    task automatic access(input logic [17:0] a, input logic [15:0] word, input bit miss,
                          input logic [21:0] exp_addr, input logic [7:0] exp_byte);
        exp_data_q.push_back(exp_byte);
        if (miss) exp_req_q.push_back(exp_addr);
        applyStimulus(1'b1, a);
        if (miss) begin
            waitReq();
            ackReq();
            dataRdy(word);
            checkOutput("fill_ok", 32'(bus.ok), 32'd1);
        end else begin
            #1;
            checkOutput("hit_ok", 32'(bus.ok), 32'd1);
        end
        tick();
    endtask

    // Monitor: check every new SDRAM request and every newly valid byte
    always @(negedge clk) begin
        if (bus.sdram_req && !prev_req) begin
            req_count++;
            if (exp_req_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_req: got addr %0h, expected no request", bus.sdram_addr);
            end else begin
                mon_req = exp_req_q.pop_front();
                checkOutput("sdram_addr", 32'(bus.sdram_addr), 32'(mon_req));
            end
        end
        if (bus.ok && (!prev_ok || bus.addr != prev_addr)) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_ok: got ok at addr %0h dout %0h, expected ok=0", bus.addr, bus.dout);
            end else begin
                mon_data = exp_data_q.pop_front();
                checkOutput("dout", 32'(bus.dout), 32'(mon_data));
            end
        end
        prev_req  = bus.sdram_req;
        prev_ok   = bus.ok;
        prev_addr = bus.addr;
    end

    initial begin
        int viol;
        int reads_before;
        bit miss;
        logic [17:0] a;

        bus.cs          = 1'b0;
        bus.addr        = '0;
        bus.downloading = 1'b0;
        bus.sdram_ack   = 1'b0;
        bus.data_rdy    = 1'b0;
        bus.data_read   = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        checkOutput("rst_req", 32'(bus.sdram_req), 32'd0);
        checkOutput("rst_ok", 32'(bus.ok), 32'd0);
        checkOutput("rst_dout", 32'(bus.dout), 32'd0);
        checkOutput("rst_sdram_addr", 32'(bus.sdram_addr), 32'd0);
        rst = 1'b0;
        tick();

        // 1: miss on addr 0x10 -> word 0x1008, low byte of BEEF
        $display("[TB] test 1: first miss");
        exp_req_q.push_back(22'h1008);
        exp_data_q.push_back(8'hEF);
        applyStimulus(1'b1, 18'h10);
        #1;
        checkOutput("miss_ok_low", 32'(bus.ok), 32'd0);
        waitReq();
        ackReq();
        checkOutput("wait_req_low", 32'(bus.sdram_req), 32'd0);
        checkOutput("wait_ok_low", 32'(bus.ok), 32'd0);
        dataRdy(16'hBEEF);
        checkOutput("t1_ok", 32'(bus.ok), 32'd1);
        tick();

        // 2: odd byte of the same word hits in the same cycle
        $display("[TB] test 2: same-word hit");
        exp_data_q.push_back(8'hBE);
        applyStimulus(1'b1, 18'h11);
        #1;
        checkOutput("t2_ok", 32'(bus.ok), 32'd1);
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.sdram_req) viol++;
        end
        checkOutput("t2_no_req", 32'(viol), 32'd0);

        // 3: address moves during WAIT; stale fill must not raise ok
        $display("[TB] test 3: address change in WAIT");
        exp_req_q.push_back(22'h1010);
        applyStimulus(1'b1, 18'h20);
        waitReq();
        ackReq();
        exp_req_q.push_back(22'h1020);
        exp_data_q.push_back(8'h78);
        applyStimulus(1'b1, 18'h40);
        dataRdy(16'h1234);
        checkOutput("t3_stale_ok", 32'(bus.ok), 32'd0);
        waitReq();
        ackReq();
        dataRdy(16'h5678);
        checkOutput("t3_ok", 32'(bus.ok), 32'd1);
        tick();

        // 4a: downloading drops ok at once and invalidates the cache
        $display("[TB] test 4: downloading");
        bus.downloading = 1'b1;
        #1;
        checkOutput("dl_ok_low", 32'(bus.ok), 32'd0);
        repeat (3) tick();
        exp_req_q.push_back(22'h1020);
        exp_data_q.push_back(8'h78);
        bus.downloading = 1'b0;
        waitReq();
        ackReq();
        dataRdy(16'h5678);
        checkOutput("t4a_ok", 32'(bus.ok), 32'd1);
        tick();

        // 4b: downloading in WAIT, late data_rdy ignored, re-request
        exp_req_q.push_back(22'h1040);
        applyStimulus(1'b1, 18'h80);
        waitReq();
        ackReq();
        bus.downloading = 1'b1;
        #1;
        checkOutput("dl_wait_req", 32'(bus.sdram_req), 32'd0);
        checkOutput("dl_wait_ok", 32'(bus.ok), 32'd0);
        repeat (4) tick();
        exp_req_q.push_back(22'h1040);
        exp_data_q.push_back(8'hDE);
        bus.downloading = 1'b0;
        dataRdy(16'hDEAD);
        checkOutput("late_rdy_req", 32'(bus.sdram_req), 32'd1);
        dataRdy(16'hDEAD);
        checkOutput("rdy_in_req_ok", 32'(bus.ok), 32'd0);
        checkOutput("rdy_in_req_req", 32'(bus.sdram_req), 32'd1);
        ackReq();
        dataRdy(16'hC0DE);
        checkOutput("t4b_ok", 32'(bus.ok), 32'd1);
        tick();

        // 5: cs low for 100 cycles never requests and never flags ok
        $display("[TB] test 5: cs low");
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            a = 18'(i * 18'h123);
            applyStimulus(1'b0, a);
            #1;
            if (bus.ok || bus.sdram_req) viol++;
            tick();
            if (bus.ok || bus.sdram_req) viol++;
        end
        checkOutput("cs_low_quiet", 32'(viol), 32'd0);

        // 6: alternating addresses; then a third address exercises eviction
        $display("[TB] test 6: alternating addresses");
        reads_before = req_count;
        for (int i = 0; i < 10; i++) begin
            miss = DUAL ? (i < 2) : 1'b1;
            if (i % 2 == 0) access(18'h100, 16'hA1B2, miss, 22'h1080, 8'hB2);
            else            access(18'h200, 16'hC3D4, miss, 22'h1100, 8'hD4);
        end
        checkOutput("alt_reads", 32'(req_count - reads_before), DUAL ? 32'd2 : 32'd10);
        access(18'h300, 16'hE5F6, 1'b1, 22'h1180, 8'hF6);
        access(18'h200, 16'hC3D4, !DUAL, 22'h1100, 8'hD4);
        access(18'h100, 16'hA1B2, 1'b1, 22'h1080, 8'hB2);

        // Reset pulse while a request is pending clears everything
        $display("[TB] test 6: reset mid-request");
        exp_req_q.push_back(22'h1200);
        applyStimulus(1'b1, 18'h400);
        waitReq();
        applyStimulus(1'b0, 18'h100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_req", 32'(bus.sdram_req), 32'd0);
        checkOutput("rst_mid_addr", 32'(bus.sdram_addr), 32'd0);
        checkOutput("rst_mid_dout", 32'(bus.dout), 32'd0);
        exp_req_q.push_back(22'h1080);
        exp_data_q.push_back(8'h88);
        applyStimulus(1'b1, 18'h100);
        #1;
        checkOutput("rst_invalid_ok", 32'(bus.ok), 32'd0);
        waitReq();
        ackReq();
        dataRdy(16'h7788);
        checkOutput("post_rst_ok", 32'(bus.ok), 32'd1);
        tick();

        applyStimulus(1'b0, 18'h0);
        repeat (2) tick();
        checkOutput("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        checkOutput("data_queue_drained", 32'(exp_data_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
